// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks DEPTH in-flight destinations past execute, picks bypass sources
// and flags load-use stalls. Statistics counters are built only with FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned OVF_REG = 30,
  localparam int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              advance_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] x_rd_i,
  input  logic              x_wr_i,
  input  logic              x_load_i,
  input  logic              x_ovf_i,
  input  logic [REG_AW-1:0] x_rs_i,
  input  logic [REG_AW-1:0] x_rt_i,
  input  logic              x_rs_used_i,
  input  logic              x_rt_used_i,
  output logic [SEL_W-1:0]  sel_a_o,
  output logic [SEL_W-1:0]  sel_b_o,
  output logic              stall_o,
  output logic [31:0]       fwd_count_o,
  output logic [31:0]       stall_count_o
);

  // Index 0 holds entry 1 (youngest).
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  load_q, load_d;
  logic [REG_AW-1:0] tag_q [DEPTH];
  logic [REG_AW-1:0] tag_d [DEPTH];

  logic [REG_AW-1:0] cap_tag;
  logic              cap_valid;

  assign cap_tag   = x_ovf_i ? REG_AW'(OVF_REG) : x_rd_i;
  assign cap_valid = x_wr_i && (cap_tag != '0);

  always_comb begin
    sel_a_o = '0;
    sel_b_o = '0;
    // Walk oldest to youngest so the nearest match wins.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && !(k == 0 && load_q[k])) begin
        if (x_rs_used_i && (x_rs_i != '0) && (tag_q[k] == x_rs_i)) sel_a_o = SEL_W'(k + 1);
        if (x_rt_used_i && (x_rt_i != '0) && (tag_q[k] == x_rt_i)) sel_b_o = SEL_W'(k + 1);
      end
    end
  end

  assign stall_o = valid_q[0] && load_q[0] && (tag_q[0] != '0) &&
                   ((x_rs_used_i && (tag_q[0] == x_rs_i)) ||
                    (x_rt_used_i && (tag_q[0] == x_rt_i)));

  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    for (int k = 0; k < DEPTH; k++) tag_d[k] = tag_q[k];
    if (advance_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        load_d[k]  = load_q[k-1];
        tag_d[k]   = tag_q[k-1];
      end
      // A stalled or flushed execute instruction leaves a single bubble.
      valid_d[0] = cap_valid && !stall_o && !flush_i;
      load_d[0]  = x_load_i;
      tag_d[0]   = cap_tag;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      load_q  <= '0;
      for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      for (int k = 0; k < DEPTH; k++) tag_q[k] <= tag_d[k];
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] fwd_count_q, fwd_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic [1:0]  fwd_inc;
  logic [32:0] fwd_sum;

  assign fwd_inc = {1'b0, (sel_a_o != '0)} + {1'b0, (sel_b_o != '0)};
  assign fwd_sum = {1'b0, fwd_count_q} + 33'(fwd_inc);

  always_comb begin
    fwd_count_d   = fwd_count_q;
    stall_count_d = stall_count_q;
    if (advance_i && !stall_o) begin
      fwd_count_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
    if (advance_i && stall_o && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      fwd_count_q   <= fwd_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_count_o   = fwd_count_q;
  assign stall_count_o = stall_count_q;
`else
  assign fwd_count_o   = '0;
  assign stall_count_o = '0;
`endif

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter DEPTH, default 2, number of tracked in-flight stages after execute; legal range 2..8.
REQ-003 SHALL have parameter OVF_REG, default 30, register written on overflow.
REQ-004 SHALL have localparam SEL_W = clog2(DEPTH+1), bypass-select width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clock  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 advance  in  1  pipeline advances this cycle.
REQ-008 flush  in  1  kill the instruction leaving execute.
REQ-009 x_rd  in  REG_AW  destination of execute-stage instruction.
REQ-010 x_wr  in  1  execute-stage instruction writes x_rd.
REQ-011 x_load  in  1  execute-stage instruction is a load.
REQ-012 x_ovf  in  1  execute-stage ALU overflow; destination becomes OVF_REG.
REQ-013 x_rs, x_rt  in  REG_AW each  source registers of the instruction in execute.
REQ-014 x_rs_used, x_rt_used  in  1 each  source actually read.
REQ-015 sel_a, sel_b  out  SEL_W each  0 = register file, k = forward from stage k (1 = nearest).
REQ-016 stall  out  1  load-use hazard; hold execute.
REQ-017 fwd_count, stall_count  out  32 each  statistics (see Configuration).

Function
REQ-018 SHALL hold DEPTH entries {valid, tag, load}; entry 1 is youngest.
REQ-019 Captured tag SHALL be OVF_REG when x_ovf=1, else x_rd; entry valid = x_wr and captured tag != 0.
REQ-020 On a rising edge with advance=1, stall=0 and flush=0, entry 1 SHALL load the captured execute instruction; entry k SHALL load entry k-1; entry DEPTH SHALL be discarded.
REQ-021 On a rising edge with advance=1 and (stall=1 or flush=1), entry 1 SHALL become invalid (bubble); deeper entries SHALL shift as in REQ-020.
REQ-022 With advance=0, all entries SHALL hold.
REQ-023 sel_a SHALL be the smallest k where entry k is valid, tag == x_rs, and x_rs_used=1, excluding k=1 with load=1; otherwise 0. sel_b SHALL be identical using x_rt/x_rt_used.
REQ-024 Register 0 SHALL never be forwarded.
REQ-025 stall SHALL be 1 when entry 1 is valid with load=1 and its tag matches a used source; otherwise 0.
REQ-026 When stall=1, sel_a and sel_b SHALL still reflect REQ-023.
REQ-027 All outputs SHALL be combinational from entries and current inputs; forwarding latency SHALL be zero cycles.
REQ-028 When advance=1 and flush=1 coincide with stall=1, the result SHALL be a single bubble.

Reset
REQ-029 Asserting reset (low) SHALL asynchronously clear all valid bits and both counters.
REQ-030 During and immediately after reset, sel_a=sel_b=0 and stall=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight entries.

Configuration
REQ-032 Macro FWD_SCOREBOARD_STATS_EN SHALL gate the statistics feature.
REQ-033 Defined: on each edge with advance=1 and stall=0, fwd_count SHALL add the number of nonzero selects (0..2).
REQ-034 Defined: on each edge with advance=1 and stall=1, stall_count SHALL increment; both counters SHALL saturate at 32'hFFFFFFFF.
REQ-035 Undefined: no counter state is built; fwd_count and stall_count SHALL read 0 constantly.

Verification
REQ-036 ALU chain: issue rd=5 (x_wr=1), advance; next x_rs=5 used -> sel_a=1; advance a bubble -> sel_a=2; advance again -> sel_a=0.
REQ-037 Nearest wins: entries 1 and 2 both tag 7; x_rt=7 used -> sel_b=1.
REQ-038 Load-use: load rd=3 in entry 1, x_rs=3 used -> stall=1, sel_a=0; advance -> entry 2 holds load, stall=0, sel_a=2.
REQ-039 Overflow and r0: issue x_rd=4, x_ovf=1 -> x_rs=30 gives sel_a=1 and x_rs=4 gives sel_a=0; issue x_rd=0, x_wr=1 -> x_rs=0 gives sel_a=0.
REQ-040 Flush and hold: flush=1 with advance=1 -> entry 1 invalid; advance=0 for 3 cycles -> sel values unchanged.
REQ-041 Reset mid-flight and stats: drive reset low with entries valid -> selects 0 immediately. With STATS_EN, one two-operand forward plus one stall -> fwd_count=2, stall_count=1.
